// File: rtl/axi_arb_pkg.sv
// Widths, channel payload types and FSM encoding shared by the two-port AXI
// write arbiter, its outstanding counters and its interfaces.
package axi_arb_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int RESP_W  = 2;
  localparam int MID_W   = ID_W + 1;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } axi_aw_t;

  typedef struct packed {
    logic [MID_W-1:0]   id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } axi_maw_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RESP_W-1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [MID_W-1:0]  id;
    logic [RESP_W-1:0] resp;
  } axi_mb_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // The source port rides in the extra ID MSB so B can be routed back.
  function automatic axi_maw_t widen_aw(input logic port, input axi_aw_t aw);
    axi_maw_t r;
    r.id    = {port, aw.id};
    r.addr  = aw.addr;
    r.len   = aw.len;
    r.size  = aw.size;
    r.burst = aw.burst;
    return r;
  endfunction

  function automatic axi_b_t strip_b(input axi_mb_t b);
    axi_b_t r;
    r.id   = b.id[ID_W-1:0];
    r.resp = b.resp;
    return r;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Write-only AXI bundles: narrow-ID slave-side ports and the widened-ID master.
// Every channel transfers on a cycle where valid && ready; a source holds valid
// and payload stable until that cycle, and valid never waits on ready.
interface axi_wr_s_if;
  import axi_arb_pkg::*;

  logic    awvalid;
  logic    awready;
  axi_aw_t aw;
  logic    wvalid;
  logic    wready;
  axi_w_t  w;
  logic    bvalid;
  logic    bready;
  axi_b_t  b;

  modport master (output awvalid, aw, wvalid, w, bready,
                  input  awready, wready, bvalid, b);
  modport slave  (input  awvalid, aw, wvalid, w, bready,
                  output awready, wready, bvalid, b);
endinterface

interface axi_wr_m_if;
  import axi_arb_pkg::*;

  logic     awvalid;
  logic     awready;
  axi_maw_t aw;
  logic     wvalid;
  logic     wready;
  axi_w_t   w;
  logic     bvalid;
  logic     bready;
  axi_mb_t  b;

  modport master (output awvalid, aw, wvalid, w, bready,
                  input  awready, wready, bvalid, b);
  modport slave  (input  awvalid, aw, wvalid, w, bready,
                  output awready, wready, bvalid, b);
endinterface

// File: rtl/axi_outstanding_cnt.sv
// Saturating up/down count of write bursts accepted but not yet responded to;
// full stops further grants to the owning port.
module axi_outstanding_cnt
  import axi_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (inc && !dec && count != MAX_C) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign full = (count == MAX_C);

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-into-one AXI write arbiter: one burst at a time owns AW then W on the
// master; B is steered back by the port bit carried in the ID MSB.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             aclk,
  input  logic             areset,
  axi_wr_s_if.slave        s0,
  axi_wr_s_if.slave        s1,
  axi_wr_m_if.master       m,
  output arb_state_t       dbg_state,
  output logic             dbg_grant,
  output logic [CNT_W-1:0] dbg_out0,
  output logic [CNT_W-1:0] dbg_out1
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  axi_maw_t   maw_q, maw_d;

  logic       full0, full1;
  logic       req0, req1, win;
  logic       sel_wvalid;
  axi_w_t     sel_w;
  logic       bport;
  logic [CNT_W-1:0] cnt0, cnt1;

  assign req0 = s0.awvalid & ~full0;
  assign req1 = s1.awvalid & ~full1;

  // On a tie the port that did not win last time goes next.
  assign win = (req0 & req1) ? ~last_q : req1;

  assign sel_wvalid = grant_q ? s1.wvalid : s0.wvalid;
  assign sel_w      = grant_q ? s1.w      : s0.w;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    maw_d      = maw_q;
    s0.awready = 1'b0;
    s1.awready = 1'b0;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    s0.wready  = 1'b0;
    s1.wready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          s0.awready = ~win;
          s1.awready = win;
          grant_d    = win;
          last_d     = win;
          maw_d      = widen_aw(win, win ? s1.aw : s0.aw);
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m.awvalid = 1'b1;
        if (m.awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        m.wvalid  = sel_wvalid;
        s0.wready = ~grant_q & m.wready;
        s1.wready = grant_q & m.wready;
        if (sel_wvalid && m.wready && sel_w.last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      maw_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      maw_q   <= maw_d;
    end
  end

  assign m.aw = maw_q;
  assign m.w  = sel_w;

  // Response steering does not depend on the FSM.
  assign bport     = m.b.id[MID_W-1];
  assign s0.bvalid = m.bvalid & ~bport;
  assign s1.bvalid = m.bvalid & bport;
  assign s0.b      = strip_b(m.b);
  assign s1.b      = strip_b(m.b);
  assign m.bready  = bport ? s1.bready : s0.bready;

  axi_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt0 (
    .aclk   (aclk),
    .areset (areset),
    .inc    (s0.awvalid & s0.awready),
    .dec    (s0.bvalid & s0.bready),
    .count  (cnt0),
    .full   (full0)
  );

  axi_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt1 (
    .aclk   (aclk),
    .areset (areset),
    .inc    (s1.awvalid & s1.awready),
    .dec    (s1.bvalid & s1.bready),
    .count  (cnt1),
    .full   (full1)
  );

  assign dbg_state = state_q;
  assign dbg_grant = grant_q;
  assign dbg_out0  = cnt0;
  assign dbg_out1  = cnt1;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: directed scenarios and a random soak, all checked
// against a transaction-level model of the arbitration and routing rules.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int MAX_OUT = 2;
  localparam int MAW_W   = $bits(axi_maw_t);

  // clock / reset
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi_wr_s_if s0 ();
  axi_wr_s_if s1 ();
  axi_wr_m_if m ();

  arb_state_t       dbg_state;
  logic             dbg_grant;
  logic [CNT_W-1:0] dbg_out0, dbg_out1;

  axi_wr_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s0        (s0),
    .s1        (s1),
    .m         (m),
    .dbg_state (dbg_state),
    .dbg_grant (dbg_grant),
    .dbg_out0  (dbg_out0),
    .dbg_out1  (dbg_out1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // stimulus knobs (percent chances) and driven values
  int p_aw, p_w, p_mawr, p_mwr, p_b, p_brdy;
  int force_id, force_len;
  int n_left [2];
  logic    awv [2];
  axi_aw_t aw_d [2];
  logic    wv [2];
  logic    w_own [2];
  axi_w_t  w_d [2];
  logic    brdy [2];
  logic    mawr, mwr, bv;
  axi_mb_t b_d;

  // reference model: one in-flight burst record plus per-port open counts
  bit      in_fl, addr_sent;
  int      fl_port, fl_beat, last_win;
  axi_aw_t fl_aw;
  int      out_cnt [2];
  axi_mb_t b_q [$];
  logic [MAW_W-1:0] exp_q [$];

  int n_grant [2];
  int n_w_hs;
  int grant_log [$];
  int msb_log [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  function automatic axi_aw_t rand_aw();
    axi_aw_t a;
    a.id    = (force_id >= 0) ? ID_W'(force_id) : ID_W'($urandom);
    a.addr  = $urandom;
    a.len   = (force_len >= 0) ? LEN_W'(force_len) : LEN_W'($urandom_range(3, 0));
    a.size  = 3'd2;
    a.burst = 2'b01;
    return a;
  endfunction

  function automatic logic [MAW_W-1:0] exp_maw(input int port, input axi_aw_t a);
    return {1'(port), a};
  endfunction

  // driver tasks
  task automatic drive();
    s0.awvalid = awv[0]; s0.aw = aw_d[0]; s0.wvalid = wv[0]; s0.w = w_d[0]; s0.bready = brdy[0];
    s1.awvalid = awv[1]; s1.aw = aw_d[1]; s1.wvalid = wv[1]; s1.w = w_d[1]; s1.bready = brdy[1];
    m.awready = mawr; m.wready = mwr; m.bvalid = bv; m.b = b_d;
  endtask

  task automatic clear_stats();
    n_grant = '{0, 0};
    n_w_hs = 0;
    grant_log.delete();
    msb_log.delete();
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    drive();
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_grant", dbg_grant, 1'b0);
    chk("rst_m_awvalid", m.awvalid, 1'b0);
    chk("rst_m_aw", m.aw, '0);
    chk("rst_m_wvalid", m.wvalid, 1'b0);
    chk("rst_out0", dbg_out0, '0);
    chk("rst_out1", dbg_out1, '0);
    awv = '{1'b0, 1'b0}; wv = '{1'b0, 1'b0}; w_own = '{1'b0, 1'b0}; bv = 1'b0;
    drive();
    in_fl = 0; addr_sent = 0; last_win = 1; out_cnt = '{0, 0};
    b_q.delete(); exp_q.delete();
    clear_stats();
    areset = 1'b0;
  endtask

  // one clock: drive after the edge, check and advance the model mid-cycle
  task automatic step();
    bit req0, req1, e_awr0, e_awr1, e_mawv, e_data, e_mwv, e_wr0, e_wr1, e_bv0, e_bv1, e_mbr;
    int win, bp;
    axi_b_t  e_b;
    axi_mb_t nb;
    @(posedge aclk); #1;
    for (int p = 0; p < 2; p++) begin
      if (!awv[p] && n_left[p] > 0 && roll(p_aw)) begin
        awv[p] = 1'b1;
        aw_d[p] = rand_aw();
      end
      if (in_fl && fl_port == p) begin
        if (!(wv[p] && w_own[p])) begin
          wv[p] = roll(p_w);
          w_own[p] = 1'b1;
          w_d[p].data = $urandom;
          w_d[p].strb = '1;
          w_d[p].last = (fl_beat == int'(fl_aw.len));
        end
      end else begin
        w_own[p] = 1'b0;
        wv[p] = roll(20);
        w_d[p].data = $urandom;
        w_d[p].strb = STRB_W'($urandom);
        w_d[p].last = 1'($urandom);
      end
      brdy[p] = roll(p_brdy);
    end
    mawr = roll(p_mawr);
    mwr  = roll(p_mwr);
    if (!bv) begin
      if (b_q.size() > 0 && roll(p_b)) begin
        bv = 1'b1;
        b_d = b_q[0];
      end else begin
        b_d.id = MID_W'($urandom);
        b_d.resp = RESP_W'($urandom);
      end
    end
    drive();
    @(negedge aclk);

    req0 = awv[0] && out_cnt[0] < MAX_OUT;
    req1 = awv[1] && out_cnt[1] < MAX_OUT;
    win = -1;
    if (!in_fl) begin
      if (req0 && req1) win = 1 - last_win;
      else if (req0) win = 0;
      else if (req1) win = 1;
    end
    e_awr0 = (win == 0);
    e_awr1 = (win == 1);
    e_mawv = in_fl && !addr_sent;
    e_data = in_fl && addr_sent;
    e_mwv  = e_data && wv[fl_port];
    e_wr0  = e_data && fl_port == 0 && mwr;
    e_wr1  = e_data && fl_port == 1 && mwr;
    bp     = int'(b_d.id[ID_W]);
    e_bv0  = bv && bp == 0;
    e_bv1  = bv && bp == 1;
    e_mbr  = brdy[bp];
    e_b.id = b_d.id[ID_W-1:0];
    e_b.resp = b_d.resp;

    chk("s0_awready", s0.awready, e_awr0);
    chk("s1_awready", s1.awready, e_awr1);
    chk("m_awvalid", m.awvalid, e_mawv);
    chk("m_wvalid", m.wvalid, e_mwv);
    chk("s0_wready", s0.wready, e_wr0);
    chk("s1_wready", s1.wready, e_wr1);
    chk("s0_bvalid", s0.bvalid, e_bv0);
    chk("s1_bvalid", s1.bvalid, e_bv1);
    chk("m_bready", m.bready, e_mbr);
    chk("out0", dbg_out0, out_cnt[0]);
    chk("out1", dbg_out1, out_cnt[1]);
    if (e_mawv) chk("m_aw", m.aw, exp_q[0]);
    if (e_mwv) chk("m_w", m.w, w_d[fl_port]);
    if (e_bv0) chk("s0_b", s0.b, e_b);
    if (e_bv1) chk("s1_b", s1.b, e_b);

    if (win >= 0) begin
      in_fl = 1; addr_sent = 0; fl_port = win; fl_aw = aw_d[win]; fl_beat = 0;
      last_win = win;
      out_cnt[win]++;
      exp_q.push_back(exp_maw(win, aw_d[win]));
      n_grant[win]++;
      grant_log.push_back(win);
      awv[win] = 1'b0;
      n_left[win]--;
    end else if (e_mawv && mawr) begin
      msb_log.push_back(int'(m.aw.id[ID_W]));
      void'(exp_q.pop_front());
      addr_sent = 1;
    end else if (e_mwv && mwr) begin
      n_w_hs++;
      wv[fl_port] = 1'b0;
      w_own[fl_port] = 1'b0;
      if (fl_beat == int'(fl_aw.len)) begin
        in_fl = 0;
        nb.id = {1'(fl_port), fl_aw.id};
        nb.resp = RESP_W'($urandom);
        b_q.push_back(nb);
      end else begin
        fl_beat++;
      end
    end
    if (bv && brdy[bp]) begin
      out_cnt[bp]--;
      void'(b_q.pop_front());
      bv = 1'b0;
    end
  endtask

  task automatic set_knobs(input int aw, input int w, input int mr, input int b);
    p_aw = aw; p_w = w; p_mawr = mr; p_mwr = mr; p_b = b; p_brdy = 100;
  endtask

  initial begin
    awv = '{1'b0, 1'b0}; wv = '{1'b0, 1'b0}; w_own = '{1'b0, 1'b0};
    aw_d = '{default: '0}; w_d = '{default: '0}; brdy = '{1'b0, 1'b0};
    mawr = 1'b0; mwr = 1'b0; bv = 1'b0; b_d = '0;
    n_left = '{0, 0}; force_id = -1; force_len = -1;
    set_knobs(0, 0, 0, 0);
    drive();
    do_reset();

    // single s0 burst, id 3, four beats
    set_knobs(100, 100, 100, 0);
    force_id = 3; force_len = 3; n_left = '{1, 0};
    step();
    chk("t1_s0_awready", s0.awready, 1'b1);
    step();
    chk("t1_m_awvalid_lat", m.awvalid, 1'b1);
    chk("t1_m_aw_id", m.aw.id, 5'h03);
    for (int i = 0; i < 20 && n_w_hs < 4; i++) step();
    chk("t1_beats", n_w_hs, 4);
    step();
    chk("t1_idle", dbg_state, ST_IDLE);
    p_b = 100;
    repeat (8) step();

    // both ports requesting continuously, single-beat bursts
    do_reset();
    set_knobs(100, 100, 100, 100);
    force_id = -1; force_len = 0; n_left = '{4, 4};
    for (int i = 0; i < 80 && (n_left[0] + n_left[1] > 0 || in_fl); i++) step();
    repeat (6) step();
    chk("t2_bursts", msb_log.size(), 8);
    for (int i = 0; i < 4; i++) begin
      if (i < msb_log.size()) chk($sformatf("t2_msb%0d", i), msb_log[i], i % 2);
      if (i < grant_log.size()) chk($sformatf("t2_grant%0d", i), grant_log[i], i % 2);
    end

    // B routing by the widened ID MSB
    @(posedge aclk); #1;
    m.bvalid = 1'b1; m.b.id = {1'b1, 4'd5}; m.b.resp = 2'd0;
    s0.bready = 1'b1; s1.bready = 1'b0;
    @(negedge aclk);
    chk("t3_s0_bvalid", s0.bvalid, 1'b0);
    chk("t3_s1_bvalid", s1.bvalid, 1'b1);
    chk("t3_s1_b_id", s1.b.id, 4'd5);
    chk("t3_m_bready_lo", m.bready, 1'b0);
    s1.bready = 1'b1;
    #1;
    chk("t3_m_bready_hi", m.bready, 1'b1);
    m.bvalid = 1'b0;

    // outstanding limit on s0 with responses withheld
    do_reset();
    set_knobs(100, 100, 100, 0);
    force_len = 0; n_left = '{3, 0};
    repeat (30) step();
    chk("t4_s0_grants", n_grant[0], 2);
    chk("t4_s0_out", dbg_out0, 4'd2);
    chk("t4_s0_awvalid", s0.awvalid, 1'b1);
    chk("t4_s0_blocked", s0.awready, 1'b0);
    n_left[1] = 1;
    repeat (10) step();
    chk("t4_s1_grants", n_grant[1], 1);
    chk("t4_s0_still", n_grant[0], 2);
    p_b = 100;
    repeat (20) step();
    chk("t4_s0_reenabled", n_grant[0], 3);

    // reset in the middle of a burst
    do_reset();
    set_knobs(100, 100, 100, 0);
    force_len = 3; n_left = '{1, 0};
    for (int i = 0; i < 20 && n_w_hs < 2; i++) step();
    chk("t5_beats", n_w_hs, 2);
    wv[0] = 1'b1;
    do_reset();
    force_len = 0; n_left = '{1, 1}; p_b = 100;
    step();
    chk("t5_first_s0", s0.awready, 1'b1);
    chk("t5_first_s1", s1.awready, 1'b0);
    repeat (20) step();

    // random soak
    do_reset();
    p_aw = 60; p_w = 70; p_mawr = 60; p_mwr = 70; p_b = 50; p_brdy = 60;
    force_id = -1; force_len = -1; n_left = '{60, 60};
    repeat (1500) step();
    chk("t6_progress", (n_grant[0] > 5) && (n_grant[1] > 5), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
